// File: rtl/fp_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_seq_pkg
//  Description : Shared types and constants for the floating-point datapath
//                sequencer: state encoding, operation codes, small-ALU and
//                increment/decrement command codes, exponent bias and the
//                default timing/saturation limits.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD      = 4'd1,
        S_EXP       = 4'd2,
        S_ALIGN     = 4'd3,
        S_BIAS      = 4'd4,
        S_MUL_START = 4'd5,
        S_MUL_WAIT  = 4'd6,
        S_NORM      = 4'd7,
        S_ROUND     = 4'd8,
        S_RENORM    = 4'd9,
        S_DONE      = 4'd10
    } seqState_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [3:0] INC = 4'b0001;
    localparam logic [3:0] DEC = 4'b0010;

    localparam logic [7:0] BIAS = 8'd127;

    localparam int MAX_ALIGN_DEFAULT   = 27;
    localparam int MUL_TIMEOUT_DEFAULT = 64;

    // The reserved opcode behaves exactly like an add.
    function automatic logic [1:0] normaliseOp(input logic [1:0] opIn);
        return (opIn == OP_RSVD) ? OP_ADD : opIn;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_norm_decode.sv
`default_nettype none
// ============================================================================
//  Module      : fp_norm_decode
//  Description : Combinational decode of the signed leading-one distance into
//                normalisation shift direction/amount and the matching
//                exponent increment/decrement command.
//  Ports       : i_pos           signed distance of leading one from bit 28
//                o_rightOrLeft   1 = shift right (positive distance)
//                o_howMany       shift magnitude, saturated to 23 bits
//                o_incDecCode    INC, DEC, or 0 when the distance is zero
//                o_incDecAmount  exponent adjust, saturated to 8 bits
//  Revision    : 1.0  initial release
// ============================================================================
module fp_norm_decode
    import fp_seq_pkg::*;
(
    input  logic [63:0] i_pos,
    output logic        o_rightOrLeft,
    output logic [22:0] o_howMany,
    output logic [3:0]  o_incDecCode,
    output logic [7:0]  o_incDecAmount
);

    logic        w_neg;
    logic        w_zero;
    logic [63:0] w_mag;

    assign w_neg  = i_pos[63];
    assign w_zero = (i_pos == 64'd0);
    // Magnitude of the most negative value stays 2^63; the saturation below
    // still handles it because its upper bits are non-zero.
    assign w_mag  = w_neg ? (64'd0 - i_pos) : i_pos;

    assign o_rightOrLeft  = !w_neg && !w_zero;
    assign o_incDecCode   = w_zero ? 4'd0 : (w_neg ? DEC : INC);
    assign o_howMany      = (|w_mag[63:23]) ? 23'h7FFFFF : w_mag[22:0];
    assign o_incDecAmount = (|w_mag[63:8])  ? 8'hFF      : w_mag[7:0];

endmodule
`default_nettype wire

// File: rtl/fp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fp_sequencer
//  Description : Control FSM for the single-precision FP datapath. Steps an
//                add, subtract or multiply through operand load, exponent
//                compare/sum, alignment, BigALU operation, normalisation,
//                rounding and an optional single re-normalisation, then
//                pulses done.
//  Ports       : clk, reset (sync, active-high), start/op request,
//                busy/done/error status, datapath status inputs
//                (smallAluResult, endMultiplication, rounderOverflow,
//                posFirst28posReferential) and all datapath control outputs.
//                bigAluReset is the one-cycle BigALU clear used before a
//                multiply.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_sequencer
    import fp_seq_pkg::*;
#(
    parameter int MUL_TIMEOUT = MUL_TIMEOUT_DEFAULT,
    parameter int MAX_ALIGN   = MAX_ALIGN_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [7:0]  smallAluResult,
    input  logic        endMultiplication,
    input  logic        rounderOverflow,
    input  logic [63:0] posFirst28posReferential,
    output logic        loadRegA,
    output logic        loadRegB,
    output logic        loadRegSmall,
    output logic        controlToMux01,
    output logic        controlToMux02,
    output logic        controlToMux03,
    output logic        controlToMux04,
    output logic        controlToMux05,
    output logic        IncreaseOrDecreaseEnable,
    output logic        muxAControlSmall,
    output logic        muxBControlSmall,
    output logic        sum_sub,
    output logic        isSum,
    output logic        muxDataRegValor2,
    output logic        rightOrLeft,
    output logic        bigAluReset,
    output logic [7:0]  controlShiftRight,
    output logic [3:0]  smallALUOperation,
    output logic [3:0]  controlToIncreaseOrDecrease,
    output logic [22:0] howMany,
    output logic [7:0]  howManyToIncreaseOrDecrease
);

    localparam int                 c_CNT_W     = $clog2(MUL_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_WAIT = c_CNT_W'(MUL_TIMEOUT - 1);
    localparam logic [8:0]         c_ALIGN_MAX = 9'(MAX_ALIGN);

    seqState_t          r_state;
    seqState_t          w_nextState;
    logic [1:0]         r_op;
    logic               r_error;
    logic [c_CNT_W-1:0] r_mulCount;
    logic               r_endSeen;
    logic               r_alignSelB;
    logic [7:0]         r_alignShift;
    logic               r_normRol;
    logic [22:0]        r_normHowMany;
    logic [3:0]         r_normCode;
    logic [7:0]         r_normAmount;

    logic               w_isMul;
    logic               w_isSub;
    logic               w_dNeg;
    logic [8:0]         w_dAbs;
    logic [7:0]         w_shiftSat;
    logic               w_timeout;
    logic               w_decRol;
    logic [22:0]        w_decHowMany;
    logic [3:0]         w_decCode;
    logic [7:0]         w_decAmount;

    assign w_isMul = (r_op == OP_MUL);
    assign w_isSub = (r_op == OP_SUB);

    // Nine-bit magnitude so that d = -128 yields +128 before saturation.
    assign w_dNeg     = smallAluResult[7];
    assign w_dAbs     = w_dNeg ? (9'd0 - {1'b1, smallAluResult}) : {1'b0, smallAluResult};
    assign w_shiftSat = (w_dAbs > c_ALIGN_MAX) ? c_ALIGN_MAX[7:0] : w_dAbs[7:0];

    // The product is taken one cycle after the flag, so a pending end
    // (seen now or last cycle) always wins over an expiring budget.
    assign w_timeout = (r_state == S_MUL_WAIT) && !r_endSeen && !endMultiplication
                       && (r_mulCount == c_LAST_WAIT);

    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE);
    assign error = r_error;

    fp_norm_decode u_normDecode (
        .i_pos          (posFirst28posReferential),
        .o_rightOrLeft  (w_decRol),
        .o_howMany      (w_decHowMany),
        .o_incDecCode   (w_decCode),
        .o_incDecAmount (w_decAmount)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_op          <= OP_ADD;
            r_error       <= 1'b0;
            r_mulCount    <= '0;
            r_endSeen     <= 1'b0;
            r_alignSelB   <= 1'b0;
            r_alignShift  <= 8'd0;
            r_normRol     <= 1'b0;
            r_normHowMany <= 23'd0;
            r_normCode    <= 4'd0;
            r_normAmount  <= 8'd0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_IDLE && start) begin
                r_op    <= normaliseOp(op);
                r_error <= 1'b0;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
            r_mulCount <= (r_state == S_MUL_WAIT) ? (r_mulCount + c_CNT_W'(1)) : '0;
            r_endSeen  <= (r_state == S_MUL_WAIT) && endMultiplication;
            // Alignment and normalisation decisions are made on live status
            // in their own state and then frozen for the states that follow.
            if (r_state == S_ALIGN) begin
                r_alignSelB  <= w_dNeg;
                r_alignShift <= w_shiftSat;
            end
            if (r_state == S_NORM) begin
                r_normRol     <= w_decRol;
                r_normHowMany <= w_decHowMany;
                r_normCode    <= w_decCode;
                r_normAmount  <= w_decAmount;
            end
        end
    end

    always_comb begin
        w_nextState                 = r_state;
        loadRegA                    = 1'b0;
        loadRegB                    = 1'b0;
        loadRegSmall                = 1'b0;
        controlToMux01              = 1'b0;
        controlToMux02              = 1'b0;
        controlToMux03              = 1'b0;
        controlToMux04              = 1'b0;
        controlToMux05              = 1'b0;
        IncreaseOrDecreaseEnable    = 1'b0;
        muxAControlSmall            = 1'b0;
        muxBControlSmall            = 1'b0;
        sum_sub                     = 1'b0;
        isSum                       = 1'b0;
        muxDataRegValor2            = 1'b0;
        rightOrLeft                 = 1'b0;
        bigAluReset                 = 1'b0;
        controlShiftRight           = 8'd0;
        smallALUOperation           = 4'd0;
        controlToIncreaseOrDecrease = 4'd0;
        howMany                     = 23'd0;
        howManyToIncreaseOrDecrease = 8'd0;

        // Add/sub alignment controls: live in S_ALIGN, frozen to S_ROUND.
        // Mux select 0 = operand A, 1 = operand B.
        if (!w_isMul && (r_state == S_ALIGN || r_state == S_NORM || r_state == S_ROUND)) begin
            if (r_state == S_ALIGN) begin
                controlToMux01    = w_dNeg;
                controlToMux04    = w_dNeg;
                controlToMux03    = !w_dNeg;
                controlShiftRight = w_shiftSat;
            end else begin
                controlToMux01    = r_alignSelB;
                controlToMux04    = r_alignSelB;
                controlToMux03    = !r_alignSelB;
                controlShiftRight = r_alignShift;
            end
            isSum   = 1'b1;
            sum_sub = w_isSub;
        end

        if (r_state == S_NORM) begin
            rightOrLeft                 = w_decRol;
            howMany                     = w_decHowMany;
            controlToIncreaseOrDecrease = w_decCode;
            howManyToIncreaseOrDecrease = w_decAmount;
        end else if (r_state == S_ROUND) begin
            rightOrLeft                 = r_normRol;
            howMany                     = r_normHowMany;
            controlToIncreaseOrDecrease = r_normCode;
            howManyToIncreaseOrDecrease = r_normAmount;
        end

        case (r_state)
            S_IDLE: begin
                if (start) w_nextState = S_LOAD;
            end
            S_LOAD: begin
                loadRegA    = 1'b1;
                loadRegB    = 1'b1;
                w_nextState = S_EXP;
            end
            S_EXP: begin
                loadRegSmall      = 1'b1;
                smallALUOperation = w_isMul ? ALU_ADD : ALU_SUB;
                w_nextState       = w_isMul ? S_BIAS : S_ALIGN;
            end
            S_ALIGN: begin
                w_nextState = S_NORM;
            end
            S_BIAS: begin
                // Feedback exponent sum minus the constant bias.
                smallALUOperation = ALU_SUB;
                muxAControlSmall  = 1'b1;
                muxBControlSmall  = 1'b1;
                loadRegSmall      = 1'b1;
                w_nextState       = S_MUL_START;
            end
            S_MUL_START: begin
                bigAluReset      = 1'b1;
                muxDataRegValor2 = 1'b1;
                w_nextState      = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                if (r_endSeen)      w_nextState = S_NORM;
                else if (w_timeout) w_nextState = S_DONE;
            end
            S_NORM: begin
                IncreaseOrDecreaseEnable = 1'b1;
                w_nextState              = S_ROUND;
            end
            S_ROUND: begin
                w_nextState = rounderOverflow ? S_RENORM : S_DONE;
            end
            S_RENORM: begin
                controlToMux05              = 1'b1;
                controlToMux02              = 1'b1;
                rightOrLeft                 = 1'b1;
                howMany                     = 23'd1;
                controlToIncreaseOrDecrease = INC;
                howManyToIncreaseOrDecrease = 8'd1;
                IncreaseOrDecreaseEnable    = 1'b1;
                w_nextState                 = S_DONE;
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_sequencer
//  Description : Self-checking bench for fp_sequencer. Each operation's
//                expected per-cycle control trace is derived from the cycle
//                timing rules (done at 6/7 for add/sub, 8+M(+1) for mul,
//                5+timeout on expiry) and the alignment/normalisation rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_sequencer;
    import fp_seq_pkg::*;

    localparam int TIMEOUT   = 64;
    localparam int ALIGN_MAX = 27;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        busy, done, error;
    logic [7:0]  smallAluResult;
    logic        endMultiplication, rounderOverflow;
    logic [63:0] posFirst28posReferential;
    logic        loadRegA, loadRegB, loadRegSmall;
    logic        controlToMux01, controlToMux02, controlToMux03, controlToMux04, controlToMux05;
    logic        IncreaseOrDecreaseEnable, muxAControlSmall, muxBControlSmall;
    logic        sum_sub, isSum, muxDataRegValor2, rightOrLeft, bigAluReset;
    logic [7:0]  controlShiftRight;
    logic [3:0]  smallALUOperation, controlToIncreaseOrDecrease;
    logic [22:0] howMany;
    logic [7:0]  howManyToIncreaseOrDecrease;

    int checks   = 0;
    int failures = 0;
    bit prevErr  = 1'b0;

    fp_sequencer #(.MUL_TIMEOUT(TIMEOUT), .MAX_ALIGN(ALIGN_MAX)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .busy(busy), .done(done), .error(error),
        .smallAluResult(smallAluResult),
        .endMultiplication(endMultiplication),
        .rounderOverflow(rounderOverflow),
        .posFirst28posReferential(posFirst28posReferential),
        .loadRegA(loadRegA), .loadRegB(loadRegB), .loadRegSmall(loadRegSmall),
        .controlToMux01(controlToMux01), .controlToMux02(controlToMux02),
        .controlToMux03(controlToMux03), .controlToMux04(controlToMux04),
        .controlToMux05(controlToMux05),
        .IncreaseOrDecreaseEnable(IncreaseOrDecreaseEnable),
        .muxAControlSmall(muxAControlSmall), .muxBControlSmall(muxBControlSmall),
        .sum_sub(sum_sub), .isSum(isSum), .muxDataRegValor2(muxDataRegValor2),
        .rightOrLeft(rightOrLeft), .bigAluReset(bigAluReset),
        .controlShiftRight(controlShiftRight),
        .smallALUOperation(smallALUOperation),
        .controlToIncreaseOrDecrease(controlToIncreaseOrDecrease),
        .howMany(howMany),
        .howManyToIncreaseOrDecrease(howManyToIncreaseOrDecrease)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no summary expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [63:0] obsStatus();
        return {61'd0, busy, done, error};
    endfunction

    function automatic logic [63:0] obsCtrl();
        return {48'd0, loadRegA, loadRegB, loadRegSmall, controlToMux01, controlToMux02,
                controlToMux03, controlToMux04, controlToMux05, IncreaseOrDecreaseEnable,
                muxAControlSmall, muxBControlSmall, sum_sub, isSum, muxDataRegValor2,
                rightOrLeft, bigAluReset};
    endfunction

    function automatic logic [63:0] obsNorm();
        return {29'd0, controlToIncreaseOrDecrease, howManyToIncreaseOrDecrease, howMany};
    endfunction

    task automatic checkIdle(input string tag, input bit expErr);
        checkValue({tag, "_status"}, obsStatus(), {61'd0, 1'b0, 1'b0, expErr});
        checkValue({tag, "_ctrl"}, obsCtrl(), 64'd0);
        checkValue({tag, "_shift"}, {56'd0, controlShiftRight}, 64'd0);
        checkValue({tag, "_alu"}, {60'd0, smallALUOperation}, 64'd0);
        checkValue({tag, "_norm"}, obsNorm(), 64'd0);
    endtask

    task automatic idleCycles(input int num);
        for (int i = 0; i < num; i++) begin
            start = 1'b0;
            op = 2'($urandom);
            smallAluResult = 8'($urandom);
            endMultiplication = 1'($urandom_range(0, 1));
            rounderOverflow = 1'($urandom_range(0, 1));
            posFirst28posReferential = {$urandom, $urandom};
            @(negedge clk);
            checkIdle("idle", prevErr);
            @(posedge clk);
            #1;
        end
    endtask

    // mWait < 0: endMultiplication never arrives (timeout).
    // abortAt >= 0: reset is asserted during that cycle of the operation.
    task automatic runOp(input logic [1:0] opIn, input int mWait, input bit ov,
                         input logic [7:0] d, input longint p, input int abortAt);
        bit          isMul, timeout, alignWin, normWin, renorm;
        int          normC, n, dv, dAbs, shiftExp;
        longint      pAbs;
        logic [3:0]  eCode, eAlu;
        logic [7:0]  eAmt;
        logic [22:0] eHm;
        logic [15:0] eCtrl;
        logic [2:0]  eStat;

        isMul    = (opIn == 2'b10);
        timeout  = isMul && (mWait < 0);
        normC    = isMul ? 6 + mWait : 4;
        n        = timeout ? 5 + TIMEOUT : normC + 2 + int'(ov);
        dv       = int'($signed(d));
        dAbs     = (dv < 0) ? -dv : dv;
        shiftExp = (dAbs > ALIGN_MAX) ? ALIGN_MAX : dAbs;
        pAbs     = (p < 0) ? -p : p;

        for (int k = 0; k <= n; k++) begin
            reset = (k == abortAt);
            start = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            op    = (k == 0) ? opIn : 2'($urandom);
            smallAluResult = (!isMul && k == 3) ? d : 8'($urandom);
            posFirst28posReferential = (k == normC) ? 64'(p) : {$urandom, $urandom};
            rounderOverflow = (k == normC + 1) ? ov : 1'($urandom_range(0, 1));
            endMultiplication = isMul ? (!timeout && k == 4 + mWait) : 1'($urandom_range(0, 1));

            alignWin = !isMul && k >= 3 && k <= 5;
            normWin  = !timeout && (k == normC || k == normC + 1);
            renorm   = !timeout && ov && (k == normC + 2);

            eStat = {(k >= 1 && k <= n), (k == n), (k == 0) ? prevErr : (timeout && k == n)};
            eCtrl = {k == 1, k == 1, (k == 2) || (isMul && k == 3),
                     alignWin && d[7], renorm, alignWin && !d[7], alignWin && d[7], renorm,
                     (normWin && k == normC) || renorm,
                     isMul && k == 3, isMul && k == 3,
                     alignWin && (opIn == 2'b01), alignWin, isMul && k == 4,
                     (normWin && p > 0) || renorm, isMul && k == 4};
            eAlu = (k == 2) ? (isMul ? 4'b0010 : 4'b0110) : ((isMul && k == 3) ? 4'b0110 : 4'd0);
            if (normWin) begin
                eCode = (p > 0) ? 4'b0001 : ((p < 0) ? 4'b0010 : 4'd0);
                eAmt  = (pAbs > 255) ? 8'hFF : 8'(pAbs);
                eHm   = (pAbs > 64'd8388607) ? 23'h7FFFFF : 23'(pAbs);
            end else if (renorm) begin
                eCode = 4'b0001; eAmt = 8'd1; eHm = 23'd1;
            end else begin
                eCode = 4'd0; eAmt = 8'd0; eHm = 23'd0;
            end

            @(negedge clk);
            checkValue($sformatf("op%0d_c%0d_status", opIn, k), obsStatus(), {61'd0, eStat});
            checkValue($sformatf("op%0d_c%0d_ctrl", opIn, k), obsCtrl(), {48'd0, eCtrl});
            checkValue($sformatf("op%0d_c%0d_shift", opIn, k), {56'd0, controlShiftRight},
                       alignWin ? 64'(shiftExp) : 64'd0);
            checkValue($sformatf("op%0d_c%0d_alu", opIn, k), {60'd0, smallALUOperation}, {60'd0, eAlu});
            checkValue($sformatf("op%0d_c%0d_norm", opIn, k), obsNorm(), {29'd0, eCode, eAmt, eHm});
            @(posedge clk);
            #1;
            if (k == abortAt) break;
        end

        reset = 1'b0;
        if (abortAt >= 0) begin
            prevErr = 1'b0;
            start = 1'b0;
            endMultiplication = 1'b0;
            @(negedge clk);
            checkIdle("after_reset", 1'b0);
            @(posedge clk);
            #1;
            idleCycles(2);
        end else begin
            prevErr = timeout;
        end
    endtask

    initial begin
        longint pr;
        int     mw;
        reset = 1'b1;
        start = 1'b0;
        op = 2'b00;
        smallAluResult = 8'd0;
        endMultiplication = 1'b0;
        rounderOverflow = 1'b0;
        posFirst28posReferential = 64'd0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkIdle("reset", 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        runOp(2'b00, 0, 1'b0, 8'd0, 64'sd1, -1);     // 1.0 + 1.0
        runOp(2'b01, 0, 1'b0, 8'd1, 64'sd0, -1);     // 3.0 - 1.0
        runOp(2'b00, 0, 1'b0, 8'd40, 64'sd0, -1);    // shift saturation
        runOp(2'b00, 0, 1'b0, 8'h80, -64'sd3, -1);   // d = -128
        runOp(2'b10, 30, 1'b0, 8'd0, 64'sd1, -1);    // mul, done at 38
        runOp(2'b10, -1, 1'b0, 8'd0, 64'sd0, -1);    // timeout, done at 69
        runOp(2'b00, 0, 1'b1, 8'hF0, 64'sd2, -1);    // renorm, error clears
        runOp(2'b11, 0, 1'b0, 8'd5, -64'sd1, -1);    // reserved op acts as add
        runOp(2'b10, 20, 1'b1, 8'd0, -64'sd5, -1);   // mul with renorm
        runOp(2'b10, -1, 1'b0, 8'd0, 64'sd0, -1);    // timeout again
        runOp(2'b10, -1, 1'b0, 8'd0, 64'sd0, 12);    // reset in S_MUL_WAIT
        runOp(2'b01, 0, 1'b0, 8'h9C, 64'sd0, 4);     // reset in S_NORM

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) == 0) pr = longint'({$urandom, $urandom}) >>> 2;
            else pr = longint'($urandom_range(0, 80)) - 40;
            mw = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 40));
            runOp(2'($urandom_range(0, 3)), mw, 1'($urandom_range(0, 1)),
                  8'($urandom), pr, -1);
            if ($urandom_range(0, 2) == 0) idleCycles(int'($urandom_range(1, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
